// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending-machine credit controller.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE,
    DONE
  } vend_state_t;

  localparam int COIN5_VAL  = 5;
  localparam int COIN10_VAL = 10;

  // Coins landing in the same cycle are credited (or rejected) as one sum.
  function automatic int coin_sum(input logic coin5, input logic coin10);
    return (coin5 ? COIN5_VAL : 0) + (coin10 ? COIN10_VAL : 0);
  endfunction

endpackage

// File: rtl/vend_edge_sync.sv
// Two-flop synchroniser for a raw asynchronous level, followed by a
// rising-edge detector that yields a single-cycle event pulse.
module vend_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_syncDly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta    <= 1'b0;
      r_sync    <= 1'b0;
      r_syncDly <= 1'b0;
    end else begin
      r_meta    <= i_async;
      r_sync    <= r_meta;
      r_syncDly <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_syncDly;

endmodule

// File: rtl/vend_credit_ctrl.sv
// Coin-credit controller: accumulates coin credit, vends, hands out change.
// Optional idle auto-refund is built when VEND_TIMEOUT_EN is defined.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE       = 15,
  parameter int CREDIT_W    = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin5_i,
  input  logic                coin10_i,
  input  logic                sel_i,
  input  logic                cancel_i,
  input  logic                change_ack_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                dispense_o,
  output logic                coin_rej_o,
  output logic                change_vld_o,
  output logic [CREDIT_W-1:0] change_amt_o,
  output logic                done_o,
  output logic                busy_o
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0]    CREDIT_MAX = SUM_W'((1 << CREDIT_W) - 1);
  localparam logic [CREDIT_W-1:0] PRICE_V    = CREDIT_W'(PRICE);

  logic w_coin5Evt;
  logic w_coin10Evt;
  logic w_selEvt;
  logic w_cancelEvt;

  vend_edge_sync u_syncCoin5 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (coin5_i),
    .o_pulse (w_coin5Evt)
  );

  vend_edge_sync u_syncCoin10 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (coin10_i),
    .o_pulse (w_coin10Evt)
  );

  vend_edge_sync u_syncSel (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (sel_i),
    .o_pulse (w_selEvt)
  );

  vend_edge_sync u_syncCancel (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (cancel_i),
    .o_pulse (w_cancelEvt)
  );

  vend_state_t         r_state;
  vend_state_t         w_stateNext;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_creditNext;
  logic [CREDIT_W-1:0] r_change;
  logic [CREDIT_W-1:0] w_changeNext;
  logic                r_coinRej;
  logic                w_coinRejNext;
  logic                w_timeoutHit;

  logic                w_coinAny;
  logic [SUM_W-1:0]    w_coinSum;
  logic [SUM_W-1:0]    w_creditSum;
  logic                w_coinFits;

  // The sum is formed one bit wider than credit so overflow is visible.
  assign w_coinAny   = w_coin5Evt | w_coin10Evt;
  assign w_coinSum   = SUM_W'(coin_sum(w_coin5Evt, w_coin10Evt));
  assign w_creditSum = {1'b0, r_credit} + w_coinSum;
  assign w_coinFits  = (w_creditSum <= CREDIT_MAX);

`ifdef VEND_TIMEOUT_EN
  localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TIMER_W-1:0] r_timer;

  // Only an accepted coin counts as activity; rejected coins and ignored
  // selects leave the refund countdown running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (r_state != CREDIT || w_stateNext != CREDIT ||
                 (w_coinAny && !w_coinRejNext)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TIMER_W'(1);
    end
  end

  assign w_timeoutHit = (r_state == CREDIT) &&
                        (r_timer == TIMER_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeoutHit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_credit  <= '0;
      r_change  <= '0;
      r_coinRej <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_credit  <= w_creditNext;
      r_change  <= w_changeNext;
      r_coinRej <= w_coinRejNext;
    end
  end

  // In CREDIT the priority is cancel, then a valid select, then coins, then
  // timeout; coins arriving alongside a cancel or vend are turned away.
  always_comb begin
    w_stateNext   = r_state;
    w_creditNext  = r_credit;
    w_changeNext  = r_change;
    w_coinRejNext = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_coinAny) begin
          if (w_coinFits) begin
            w_creditNext = w_creditSum[CREDIT_W-1:0];
            w_stateNext  = CREDIT;
          end else begin
            w_coinRejNext = 1'b1;
          end
        end
      end

      CREDIT: begin
        if (w_cancelEvt) begin
          w_changeNext  = r_credit;
          w_creditNext  = '0;
          w_coinRejNext = w_coinAny;
          w_stateNext   = CHANGE;
        end else if (w_selEvt && (r_credit >= PRICE_V)) begin
          w_coinRejNext = w_coinAny;
          w_stateNext   = VEND;
        end else if (w_coinAny && w_coinFits) begin
          w_creditNext = w_creditSum[CREDIT_W-1:0];
        end else begin
          w_coinRejNext = w_coinAny;
          if (w_timeoutHit) begin
            w_changeNext = r_credit;
            w_creditNext = '0;
            w_stateNext  = CHANGE;
          end
        end
      end

      VEND: begin
        w_coinRejNext = w_coinAny;
        w_changeNext  = r_credit - PRICE_V;
        w_creditNext  = '0;
        w_stateNext   = (r_credit != PRICE_V) ? CHANGE : DONE;
      end

      CHANGE: begin
        w_coinRejNext = w_coinAny;
        if (change_ack_i) begin
          w_stateNext = DONE;
        end
      end

      DONE: begin
        w_coinRejNext = w_coinAny;
        w_changeNext  = '0;
        w_stateNext   = IDLE;
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign credit_o     = r_credit;
  assign change_amt_o = r_change;
  assign coin_rej_o   = r_coinRej;
  assign dispense_o   = (r_state == VEND);
  assign change_vld_o = (r_state == CHANGE);
  assign done_o       = (r_state == DONE);
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl; build with VEND_TIMEOUT_EN
// defined to exercise the idle auto-refund path.
module tb_vend_credit_ctrl;

  localparam int PRICE = 15;
  localparam int CW    = 6;
  localparam int TO    = 20;

  localparam logic [3:0] M_C5  = 4'b0001;
  localparam logic [3:0] M_C10 = 4'b0010;
  localparam logic [3:0] M_SEL = 4'b0100;
  localparam logic [3:0] M_CAN = 4'b1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          coin5 = 1'b0;
  logic          coin10 = 1'b0;
  logic          sel = 1'b0;
  logic          cancel = 1'b0;
  logic          ack = 1'b0;
  logic [CW-1:0] credit;
  logic          dispense;
  logic          coinRej;
  logic          changeVld;
  logic [CW-1:0] changeAmt;
  logic          done;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int expQ[$];
  int dispCnt = 0;
  int doneCnt = 0;
  int rejCnt = 0;
  int vldSeen = 0;

  always #5 clk = ~clk;

  vend_credit_ctrl #(
    .PRICE       (PRICE),
    .CREDIT_W    (CW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin5_i      (coin5),
    .coin10_i     (coin10),
    .sel_i        (sel),
    .cancel_i     (cancel),
    .change_ack_i (ack),
    .credit_o     (credit),
    .dispense_o   (dispense),
    .coin_rej_o   (coinRej),
    .change_vld_o (changeVld),
    .change_amt_o (changeAmt),
    .done_o       (done),
    .busy_o       (busy)
  );

  // Pulse outputs are tallied on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (dispense)  dispCnt++;
    if (done)      doneCnt++;
    if (coinRej)   rejCnt++;
    if (changeVld) vldSeen++;
  end

  task automatic clearCounts();
    @(negedge clk);
    dispCnt = 0;
    doneCnt = 0;
    rejCnt  = 0;
    vldSeen = 0;
  endtask

  task automatic pulseIn(input logic [3:0] mask);
    @(negedge clk);
    coin5  = mask[0];
    coin10 = mask[1];
    sel    = mask[2];
    cancel = mask[3];
    repeat (3) @(negedge clk);
    coin5  = 1'b0;
    coin10 = 1'b0;
    sel    = 1'b0;
    cancel = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ackChange();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic coinAndCheck(input logic [3:0] mask, input int expCredit, input string tag);
    int exp;
    expQ.push_back(expCredit);
    pulseIn(mask);
    exp = expQ.pop_front();
    checks++;
    if (credit !== CW'(exp)) begin
      errors++;
      $display("[TB] FAIL %s credit got %0d want %0d", tag, credit, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({credit, changeAmt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got credit=%0d amt=%0d want 0/0", credit, changeAmt);
    end
    checks++;
    if ({dispense, coinRej, changeVld, done, busy} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 00000",
               {dispense, coinRej, changeVld, done, busy});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_vend_exact();
    clearCounts();
    coinAndCheck(M_C10, 10, "exact_c10");
    coinAndCheck(M_C5, 15, "exact_c5");
    pulseIn(M_SEL);
    repeat (2) @(negedge clk);
    checks++;
    if (dispCnt !== 1) begin
      errors++;
      $display("[TB] FAIL exact_dispense got %0d pulses want 1", dispCnt);
    end
    checks++;
    if (vldSeen !== 0) begin
      errors++;
      $display("[TB] FAIL exact_no_change got %0d vld cycles want 0", vldSeen);
    end
    checks++;
    if (doneCnt !== 1) begin
      errors++;
      $display("[TB] FAIL exact_done got %0d pulses want 1", doneCnt);
    end
    checks++;
    if ({credit, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL exact_idle got credit=%0d busy=%b want 0/0", credit, busy);
    end
  endtask

  task automatic test_change_ack();
    int exp;
    clearCounts();
    coinAndCheck(M_C10, 10, "chg_c10a");
    coinAndCheck(M_C10, 20, "chg_c10b");
    expQ.push_back(20 - PRICE);
    pulseIn(M_SEL);
    exp = expQ.pop_front();
    checks++;
    if (changeVld !== 1'b1 || changeAmt !== CW'(exp) || credit !== '0) begin
      errors++;
      $display("[TB] FAIL chg_offer got vld=%b amt=%0d credit=%0d want 1/%0d/0",
               changeVld, changeAmt, credit, exp);
    end
    checks++;
    if (dispCnt !== 1) begin
      errors++;
      $display("[TB] FAIL chg_dispense got %0d pulses want 1", dispCnt);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (changeVld !== 1'b1 || changeAmt !== CW'(exp) || doneCnt !== 0) begin
      errors++;
      $display("[TB] FAIL chg_hold got vld=%b amt=%0d done=%0d want 1/%0d/0",
               changeVld, changeAmt, doneCnt, exp);
    end
    ackChange();
    checks++;
    if (doneCnt !== 1 || changeVld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL chg_ack got done=%0d vld=%b busy=%b want 1/0/0",
               doneCnt, changeVld, busy);
    end
  endtask

  task automatic test_overflow();
    int exp;
    int total;
    clearCounts();
    coinAndCheck(M_C5 | M_C10, 15, "ovf_both");
    total = 15;
    for (int i = 0; i < 4; i++) begin
      total += 10;
      coinAndCheck(M_C10, total, "ovf_fill");
    end
    coinAndCheck(M_C5, 60, "ovf_60");
    coinAndCheck(M_C10, 60, "ovf_reject");
    checks++;
    if (rejCnt !== 1) begin
      errors++;
      $display("[TB] FAIL ovf_rej_pulse got %0d pulses want 1", rejCnt);
    end
    expQ.push_back(60);
    pulseIn(M_CAN);
    exp = expQ.pop_front();
    checks++;
    if (changeVld !== 1'b1 || changeAmt !== CW'(exp)) begin
      errors++;
      $display("[TB] FAIL ovf_refund got vld=%b amt=%0d want 1/%0d", changeVld, changeAmt, exp);
    end
    pulseIn(M_C5);
    checks++;
    if (rejCnt !== 2 || changeVld !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_coin_in_change got rej=%0d vld=%b want 2/1", rejCnt, changeVld);
    end
    ackChange();
    checks++;
    if (doneCnt !== 1 || dispCnt !== 0) begin
      errors++;
      $display("[TB] FAIL ovf_end got done=%0d disp=%0d want 1/0", doneCnt, dispCnt);
    end
  endtask

  task automatic test_sel_cancel();
    int exp;
    clearCounts();
    coinAndCheck(M_C5, 5, "sc_c5");
    coinAndCheck(M_SEL, 5, "sc_sel_low");
    checks++;
    if (busy !== 1'b1 || dispCnt !== 0) begin
      errors++;
      $display("[TB] FAIL sc_sel_ignored got busy=%b disp=%0d want 1/0", busy, dispCnt);
    end
    expQ.push_back(5);
    pulseIn(M_CAN);
    exp = expQ.pop_front();
    checks++;
    if (changeVld !== 1'b1 || changeAmt !== CW'(exp)) begin
      errors++;
      $display("[TB] FAIL sc_cancel got vld=%b amt=%0d want 1/%0d", changeVld, changeAmt, exp);
    end
    ackChange();
    coinAndCheck(M_C10, 10, "sc_c10");
    coinAndCheck(M_C5, 15, "sc_c5b");
    expQ.push_back(15);
    pulseIn(M_SEL | M_CAN);
    exp = expQ.pop_front();
    checks++;
    if (changeVld !== 1'b1 || changeAmt !== CW'(exp) || dispCnt !== 0) begin
      errors++;
      $display("[TB] FAIL sc_cancel_wins got vld=%b amt=%0d disp=%0d want 1/%0d/0",
               changeVld, changeAmt, dispCnt, exp);
    end
    ackChange();
    checks++;
    if (doneCnt !== 2) begin
      errors++;
      $display("[TB] FAIL sc_done got %0d pulses want 2", doneCnt);
    end
  endtask

  task automatic test_reset_mid();
    int exp;
    clearCounts();
    coinAndCheck(M_C5, 5, "rm_c5");
    expQ.push_back(5);
    pulseIn(M_CAN);
    exp = expQ.pop_front();
    checks++;
    if (changeVld !== 1'b1 || changeAmt !== CW'(exp)) begin
      errors++;
      $display("[TB] FAIL rm_change got vld=%b amt=%0d want 1/%0d", changeVld, changeAmt, exp);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({credit, changeAmt, dispense, coinRej, changeVld, done, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL rm_async_clear got credit=%0d amt=%0d flags=%b want all 0",
               credit, changeAmt, {dispense, coinRej, changeVld, done, busy});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clearCounts();
    repeat (10) @(negedge clk);
    checks++;
    if (doneCnt !== 0 || busy !== 1'b0 || credit !== '0) begin
      errors++;
      $display("[TB] FAIL rm_after got done=%0d busy=%b credit=%0d want 0/0/0",
               doneCnt, busy, credit);
    end
  endtask

`ifdef VEND_TIMEOUT_EN
  task automatic test_timeout();
    int waited;
    clearCounts();
    coinAndCheck(M_C5, 5, "to_c5");
    repeat (16) @(negedge clk);
    checks++;
    if (changeVld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_early got vld=%b want 0", changeVld);
    end
    @(negedge clk);
    checks++;
    if (changeVld !== 1'b1 || changeAmt !== CW'(5)) begin
      errors++;
      $display("[TB] FAIL to_refund got vld=%b amt=%0d want 1/5", changeVld, changeAmt);
    end
    ackChange();
    coinAndCheck(M_C5, 5, "to_c5b");
    repeat (12) @(negedge clk);
    coinAndCheck(M_C5, 10, "to_restart_coin");
    checks++;
    if (changeVld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_restart got vld=%b want 0", changeVld);
    end
    waited = 0;
    while (changeVld !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited !== 17 || changeAmt !== CW'(10)) begin
      errors++;
      $display("[TB] FAIL to_second got wait=%0d amt=%0d want 17/10", waited, changeAmt);
    end
    ackChange();
  endtask
`else
  task automatic test_timeout();
    clearCounts();
    coinAndCheck(M_C5, 5, "nto_c5");
    repeat (60) @(negedge clk);
    checks++;
    if (vldSeen !== 0 || credit !== CW'(5) || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nto_persist got vld=%0d credit=%0d busy=%b want 0/5/1",
               vldSeen, credit, busy);
    end
    pulseIn(M_CAN);
    ackChange();
  endtask
`endif

  initial begin
    test_reset();
    test_vend_exact();
    test_change_ack();
    test_overflow();
    test_sel_cancel();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
